// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine change sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_N,
        COIN_D,
        COIN_Q
    } coin_e;

    // Coin values expressed in nickel units.
    localparam int unsigned VAL_N = 1;
    localparam int unsigned VAL_D = 2;
    localparam int unsigned VAL_Q = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    function automatic int unsigned coin_value(input coin_e c);
        case (c)
            COIN_N:  return VAL_N;
            COIN_D:  return VAL_D;
            COIN_Q:  return VAL_Q;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_coin_select.sv
// Greedy coin chooser: largest stocked coin that does not exceed the amount still owed.
module vend_coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic             avail_n,
    input  logic             avail_d,
    input  logic             avail_q,
    output coin_e            coin
);

    always_comb begin
        coin = COIN_NONE;
        if (remaining >= AMT_W'(VAL_Q) && avail_q) begin
            coin = COIN_Q;
        end else if (remaining >= AMT_W'(VAL_D) && avail_d) begin
            coin = COIN_D;
        end else if (remaining >= AMT_W'(VAL_N) && avail_n) begin
            coin = COIN_N;
        end
    end

endmodule

// File: rtl/vend_change_sequencer.sv
// Change sequencer: turns a nickel-unit change amount into paced N/D/Q hopper pulses.
// Optional coin inventory tracking (refill/short ports) is enabled with CHANGE_INVENTORY_EN.
module vend_change_sequencer
    import vend_pkg::*;
#(
    parameter int AMT_W     = 5,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 2,
    parameter int STOCK_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    input  logic             hopper_ready,
    output logic             N_out,
    output logic             D_out,
    output logic             Q_out,
    output logic             busy,
    output logic             done
`ifdef CHANGE_INVENTORY_EN
    ,
    input  logic             refill,
    output logic             short
`endif
);

    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (PULSE_CYC < 1 || GAP_CYC < 1 || STOCK_W < 1) begin : g_param_check
        $error("vend_change_sequencer: PULSE_CYC, GAP_CYC and STOCK_W must be >= 1");
    end

    seq_state_e       state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             n_out_q, n_out_d;
    logic             d_out_q, d_out_d;
    logic             q_out_q, q_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             req_ready_q, req_ready_d;

    logic             avail_n, avail_d, avail_q;
    coin_e            coin_sel;
    logic [AMT_W-1:0] coin_val;

`ifdef CHANGE_INVENTORY_EN
    logic [STOCK_W-1:0] stock_n_q, stock_n_d;
    logic [STOCK_W-1:0] stock_d_q, stock_d_d;
    logic [STOCK_W-1:0] stock_q_q, stock_q_d;
    logic               short_q, short_d;

    assign avail_n = (stock_n_q != '0);
    assign avail_d = (stock_d_q != '0);
    assign avail_q = (stock_q_q != '0);
`else
    assign avail_n = 1'b1;
    assign avail_d = 1'b1;
    assign avail_q = 1'b1;
`endif

    vend_coin_select #(
        .AMT_W (AMT_W)
    ) u_coin_select (
        .remaining (remaining_q),
        .avail_n   (avail_n),
        .avail_d   (avail_d),
        .avail_q   (avail_q),
        .coin      (coin_sel)
    );

    assign coin_val = AMT_W'(coin_value(coin_sel));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        n_out_d     = n_out_q;
        d_out_d     = d_out_q;
        q_out_d     = q_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        req_ready_d = req_ready_q;
`ifdef CHANGE_INVENTORY_EN
        stock_n_d   = stock_n_q;
        stock_d_d   = stock_d_q;
        stock_q_d   = stock_q_q;
        short_d     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
`ifdef CHANGE_INVENTORY_EN
                if (refill) begin
                    stock_n_d = '1;
                    stock_d_d = '1;
                    stock_q_d = '1;
                end
`endif
                if (req_valid && req_ready_q) begin
                    remaining_d = req_amt;
                    busy_d      = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = ST_SELECT;
                end
            end

            // A zero-amount request passes through SELECT once and finishes here.
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (coin_sel == COIN_NONE) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
`ifdef CHANGE_INVENTORY_EN
                    short_d = 1'b1;
`endif
                end else if (hopper_ready) begin
                    remaining_d = remaining_q - coin_val;
                    n_out_d     = (coin_sel == COIN_N);
                    d_out_d     = (coin_sel == COIN_D);
                    q_out_d     = (coin_sel == COIN_Q);
                    cnt_d       = CNT_W'(PULSE_CYC - 1);
                    state_d     = ST_PULSE;
`ifdef CHANGE_INVENTORY_EN
                    case (coin_sel)
                        COIN_N:  stock_n_d = stock_n_q - STOCK_W'(1);
                        COIN_D:  stock_d_d = stock_d_q - STOCK_W'(1);
                        COIN_Q:  stock_q_d = stock_q_q - STOCK_W'(1);
                        default: ;
                    endcase
`endif
                end
            end

            ST_PULSE: begin
                if (cnt_q == '0) begin
                    n_out_d = 1'b0;
                    d_out_d = 1'b0;
                    q_out_d = 1'b0;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (remaining_q == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DONE: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            n_out_q     <= 1'b0;
            d_out_q     <= 1'b0;
            q_out_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef CHANGE_INVENTORY_EN
            stock_n_q   <= '1;
            stock_d_q   <= '1;
            stock_q_q   <= '1;
            short_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            n_out_q     <= n_out_d;
            d_out_q     <= d_out_d;
            q_out_q     <= q_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
`ifdef CHANGE_INVENTORY_EN
            stock_n_q   <= stock_n_d;
            stock_d_q   <= stock_d_d;
            stock_q_q   <= stock_q_d;
            short_q     <= short_d;
`endif
        end
    end

    assign N_out     = n_out_q;
    assign D_out     = d_out_q;
    assign Q_out     = q_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_ready = req_ready_q;
`ifdef CHANGE_INVENTORY_EN
    assign short     = short_q;
`endif

endmodule

// File: tb/tb_vend_change_sequencer.sv
// Bench for vend_change_sequencer: timeline-queue reference model, per-cycle compare, directed and random requests.
`timescale 1ns/1ps
module tb_vend_change_sequencer;

    localparam int AMT_W     = 5;
    localparam int PULSE_CYC = 2;
    localparam int GAP_CYC   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic [AMT_W-1:0] req_amt = '0;
    logic             hopper_ready = 1'b1;
    logic             req_ready, N_out, D_out, Q_out, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    vend_change_sequencer #(
        .AMT_W     (AMT_W),
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_amt      (req_amt),
        .req_ready    (req_ready),
        .hopper_ready (hopper_ready),
        .N_out        (N_out),
        .D_out        (D_out),
        .Q_out        (Q_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: each accepted request expands into a timeline of per-cycle
    // output steps; "gate" steps wait for a sampled hopper_ready before advancing.
    typedef struct packed {
        logic gate;
        logic n;
        logic d;
        logic q;
        logic bsy;
        logic dn;
    } step_t;

    step_t      plan[$];
    step_t      cur;
    bit         active   = 1'b0;
    bit         model_on = 1'b0;
    logic [5:0] exp_vec  = 6'b100000;

    function automatic step_t mk(input bit g, input bit n, input bit d, input bit q,
                                 input bit b, input bit dn);
        step_t s;
        s.gate = g; s.n = n; s.d = d; s.q = q; s.bsy = b; s.dn = dn;
        return s;
    endfunction

    task automatic build_plan(input int amt);
        int nq, nd, nn;
        bit cn, cd, cq;
        plan.delete();
        nq = amt / 5;
        nd = (amt % 5) / 2;
        nn = (amt % 5) % 2;
        if (amt == 0) plan.push_back(mk(0, 0, 0, 0, 1, 0));
        for (int i = 0; i < nq + nd + nn; i++) begin
            cq = (i < nq);
            cd = !cq && (i < nq + nd);
            cn = !cq && !cd;
            plan.push_back(mk(1, 0, 0, 0, 1, 0));
            for (int p = 0; p < PULSE_CYC; p++) plan.push_back(mk(0, cn, cd, cq, 1, 0));
            for (int g = 0; g < GAP_CYC; g++) plan.push_back(mk(0, 0, 0, 0, 1, 0));
        end
        plan.push_back(mk(0, 0, 0, 0, 0, 1));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                plan.delete();
                active = 1'b0;
            end else if (!active) begin
                if (req_valid) begin
                    build_plan(int'(req_amt));
                    cur    = plan.pop_front();
                    active = 1'b1;
                end
            end else if (cur.gate && !hopper_ready) begin
                active = 1'b1;
            end else if (plan.size() == 0) begin
                active = 1'b0;
            end else begin
                cur = plan.pop_front();
            end
            if (active) exp_vec = {1'b0, cur.bsy, cur.dn, cur.n, cur.d, cur.q};
            else        exp_vec = 6'b100000;
            model_on = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("outputs{ready,busy,done,N,D,Q}",
                    int'({req_ready, busy, done, N_out, D_out, Q_out}), int'(exp_vec));
                chk("coin_exclusive", int'($countones({N_out, D_out, Q_out}) <= 1), 1);
            end
        end
    end

    // Issues one request from idle and observes it until done.
    // order packs the sequence of coin pulses base 4 (N=1, D=2, Q=3).
    task automatic run_req(input int amt, input int stall,
                           output int done_at, output int order, output int first_at,
                           output int coin_cyc, output int busy_cyc);
        logic [2:0] prev, now;
        prev = 3'b000;
        done_at = -1; order = 0; first_at = -1; coin_cyc = 0; busy_cyc = 0;
        req_valid    = 1'b1;
        req_amt      = AMT_W'(amt);
        hopper_ready = (stall == 0);
        @(posedge clk);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (stall != 0 && k == stall + 1) hopper_ready = 1'b1;
            now = {N_out, D_out, Q_out};
            if (now != 3'b000 && prev == 3'b000) begin
                order = order * 4 + (Q_out ? 3 : (D_out ? 2 : 1));
                if (first_at < 0) first_at = k;
            end
            if (now != 3'b000) coin_cyc++;
            if (busy) busy_cyc++;
            prev = now;
            if (done) begin
                done_at = k;
                break;
            end
        end
        if (done_at < 0) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    int done_at, order, first_at, coin_cyc, busy_cyc, dcount;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(req_ready), 1);
        chk("reset_busy_done", int'({busy, done}), 0);
        chk("reset_coins", int'({N_out, D_out, Q_out}), 0);
        reset = 1'b0;
        @(negedge clk);

        // 15c: dime then nickel
        run_req(3, 0, done_at, order, first_at, coin_cyc, busy_cyc);
        chk("amt3_done_at", done_at, 11);
        chk("amt3_order", order, 2 * 4 + 1);
        chk("amt3_coin_cycles", coin_cyc, 4);

        // 40c: quarter, dime, nickel
        run_req(8, 0, done_at, order, first_at, coin_cyc, busy_cyc);
        chk("amt8_done_at", done_at, 16);
        chk("amt8_order", order, 3 * 16 + 2 * 4 + 1);
        chk("amt8_busy_cycles", busy_cyc, 15);
        chk("amt8_first_coin", first_at, 2);

        // zero amount
        run_req(0, 0, done_at, order, first_at, coin_cyc, busy_cyc);
        chk("amt0_done_at", done_at, 2);
        chk("amt0_coin_cycles", coin_cyc, 0);
        chk("amt0_ready_after", int'(req_ready), 1);

        // hopper stalls for 10 select cycles
        run_req(5, 10, done_at, order, first_at, coin_cyc, busy_cyc);
        chk("stall_q_rise", first_at, 12);
        chk("stall_done_at", done_at, 16);
        chk("stall_order", order, 3);

        // reset during the first pulse abandons the request
        req_valid = 1'b1; req_amt = AMT_W'(8); hopper_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_q_high", int'(Q_out), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_coins", int'({N_out, D_out, Q_out}), 0);
        chk("midrst_ready", int'(req_ready), 1);
        chk("midrst_busy_done", int'({busy, done}), 0);
        reset = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("midrst_no_done", dcount, 0);
        run_req(1, 0, done_at, order, first_at, coin_cyc, busy_cyc);
        chk("after_rst_done_at", done_at, 6);
        chk("after_rst_order", order, 1);
        chk("after_rst_coin_cycles", coin_cyc, 2);

        // randomized traffic, including requests while busy and occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset        = ($urandom_range(0, 499) == 0);
            req_valid    = ($urandom_range(0, 3) == 0);
            req_amt      = AMT_W'($urandom_range(0, 31));
            hopper_ready = ($urandom_range(0, 4) != 0);
        end
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; hopper_ready = 1'b1;
        repeat (120) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
